serial_sync_ctrl: RTL and testbench

//  Synchronisation controller for the serial receive lane. Finds the 8-bit comma (COMMA) at any bit offset
//  in the clk_32f bit stream and locks the byte boundary after LOCK_COUNT aligned commas. While locked it

---
 rtl/serial_sync_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_serial_sync_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sync_ctrl.sv
// serial_sync_ctrl
//   Byte-boundary synchroniser for the serial receive lane. It finds the comma
//   symbol at any bit offset in the incoming bit stream and locks the byte
//   boundary after LOCK_COUNT aligned commas. While locked it delivers aligned
//   non-comma bytes. It drops lock on comma starvation (MAX_GAP data bytes in a
//   row) or when LOSS_COUNT off-boundary commas have been seen.
//
// Ports
//   clk_32f     in   bit clock, all logic on posedge
//   reset       in   asynchronous active-low reset
//   data_in     in   serial bit, MSB first
//   active      out  high while locked
//   valid_out   out  one-cycle pulse, data_out carries a new data byte
//   byte_strb   out  one-cycle pulse on every locked byte boundary
//   data_out    out  last delivered data byte, held between pulses
//   sync_state  out  00 search, 01 count, 10 locked
//   loss_count  out  number of lock losses, saturating at 255
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | hunting for a comma at any bit offset
// ST_COUNT   | candidate boundary found, counting aligned commas
// ST_LOCKED  | boundary locked, delivering bytes, watching for loss
// ST_BAD     | unused encoding, falls back to ST_SEARCH
module serial_sync_ctrl #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned MAX_GAP    = 16,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic       active,
   output logic       valid_out,
   output logic       byte_strb,
   output logic [7:0] data_out,
   output logic [1:0] sync_state,
   output logic [7:0] loss_count
);

   localparam int CCW = $clog2(LOCK_COUNT + 1);
   localparam int GCW = $clog2(MAX_GAP + 1);
   localparam int MCW = $clog2(LOSS_COUNT + 1);

   localparam logic [CCW-1:0] LOCK_TC = CCW'(LOCK_COUNT);
   localparam logic [GCW-1:0] GAP_TC  = GCW'(MAX_GAP);
   localparam logic [MCW-1:0] MIS_TC  = MCW'(LOSS_COUNT);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_COUNT  = 2'b01,
      ST_LOCKED = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t           state, state_nxt;
   logic [6:0]       sr, sr_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [CCW-1:0]   comma_cnt, comma_cnt_nxt, comma_inc;
   logic [GCW-1:0]   gap_cnt, gap_cnt_nxt, gap_inc;
   logic [MCW-1:0]   mis_cnt, mis_cnt_nxt, mis_inc;
   logic             active_nxt, valid_nxt, strb_nxt;
   logic [7:0]       data_nxt, loss_nxt;
   logic [7:0]       w;
   logic             boundary, is_comma, lose;

   always_comb begin
      w             = {sr, data_in};
      boundary      = (bit_cnt == 3'd7);
      is_comma      = (w == COMMA);
      comma_inc     = comma_cnt + CCW'(1);
      gap_inc       = gap_cnt + GCW'(1);
      mis_inc       = mis_cnt + MCW'(1);

      state_nxt     = state;
      sr_nxt        = w[6:0];
      bit_cnt_nxt   = bit_cnt + 3'd1;
      comma_cnt_nxt = comma_cnt;
      gap_cnt_nxt   = gap_cnt;
      mis_cnt_nxt   = mis_cnt;
      active_nxt    = active;
      valid_nxt     = 1'b0;
      strb_nxt      = 1'b0;
      data_nxt      = data_out;
      loss_nxt      = loss_count;
      lose          = 1'b0;

      case (state)
         ST_SEARCH: begin
            if (is_comma) begin
               // restart the byte phase so the next boundary lands 8 bits on
               bit_cnt_nxt   = 3'd0;
               comma_cnt_nxt = CCW'(1);
               if (LOCK_COUNT == 1) begin
                  state_nxt  = ST_LOCKED;
                  active_nxt = 1'b1;
               end else begin
                  state_nxt  = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_nxt = comma_inc;
                  if (comma_inc == LOCK_TC) begin
                     state_nxt  = ST_LOCKED;
                     active_nxt = 1'b1;
                  end
               end else begin
                  comma_cnt_nxt = '0;
                  state_nxt     = ST_SEARCH;
               end
            end
         end
         ST_LOCKED: begin
            if (boundary) begin
               strb_nxt = 1'b1;
               if (is_comma) begin
                  gap_cnt_nxt = '0;
                  mis_cnt_nxt = '0;
               end else begin
                  // the byte that exhausts the gap budget is still delivered
                  data_nxt    = w;
                  valid_nxt   = 1'b1;
                  gap_cnt_nxt = gap_inc;
                  lose        = (gap_inc == GAP_TC);
               end
            end else if (is_comma) begin
               mis_cnt_nxt = mis_inc;
               lose        = (mis_inc == MIS_TC);
            end
         end
         default: begin
            state_nxt     = ST_SEARCH;
            active_nxt    = 1'b0;
            comma_cnt_nxt = '0;
            gap_cnt_nxt   = '0;
            mis_cnt_nxt   = '0;
         end
      endcase

      if (lose) begin
         state_nxt     = ST_SEARCH;
         active_nxt    = 1'b0;
         comma_cnt_nxt = '0;
         gap_cnt_nxt   = '0;
         mis_cnt_nxt   = '0;
         if (loss_count != 8'hFF) begin
            loss_nxt = loss_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state      <= ST_SEARCH;
         sr         <= '0;
         bit_cnt    <= '0;
         comma_cnt  <= '0;
         gap_cnt    <= '0;
         mis_cnt    <= '0;
         active     <= 1'b0;
         valid_out  <= 1'b0;
         byte_strb  <= 1'b0;
         data_out   <= '0;
         loss_count <= '0;
      end else begin
         state      <= state_nxt;
         sr         <= sr_nxt;
         bit_cnt    <= bit_cnt_nxt;
         comma_cnt  <= comma_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         mis_cnt    <= mis_cnt_nxt;
         active     <= active_nxt;
         valid_out  <= valid_nxt;
         byte_strb  <= strb_nxt;
         data_out   <= data_nxt;
         loss_count <= loss_nxt;
      end
   end

   assign sync_state = state;

endmodule

// File: tb/tb_serial_sync_ctrl.sv
module tb_serial_sync_ctrl;

   localparam logic [7:0] COMMA  = 8'hBC;
   localparam int         LOCK_N = 4;
   localparam int         GAP_N  = 16;
   localparam int         MIS_N  = 4;
   // bytes that place a comma two bits past a boundary when sent back to back
   localparam logic [7:0] MIS_A  = 8'h2F;
   localparam logic [7:0] MIS_B  = 8'h00;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic       data_in = 1'b0;
   logic       active, valid_out, byte_strb;
   logic [7:0] data_out, loss_count;
   logic [1:0] sync_state;

   int checks = 0;
   int errors = 0;

   serial_sync_ctrl #(
      .COMMA      (COMMA),
      .LOCK_COUNT (LOCK_N),
      .MAX_GAP    (GAP_N),
      .LOSS_COUNT (MIS_N)
   ) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .active     (active),
      .valid_out  (valid_out),
      .byte_strb  (byte_strb),
      .data_out   (data_out),
      .sync_state (sync_state),
      .loss_count (loss_count)
   );

   always #5 clk_32f = ~clk_32f;

   // Reference model: bit history as a queue, byte phase as cycle distance
   // from the detecting comma, mode 0/1/2 = search/count/locked.
   bit         bitq[$];
   int         m_mode;
   longint     m_cyc, m_anchor;
   int         m_commas, m_gap, m_mis, m_loss;
   logic [7:0] m_data;
   bit         e_valid, e_strb;

   int          trace_bad;
   logic [20:0] first_got, first_exp;
   int          tb_cyc;
   int          n_valid;
   logic [7:0]  vq[$];
   int          vt[$];

   function automatic void model_clear();
      bitq.delete();
      m_mode = 0; m_cyc = 0; m_anchor = 0;
      m_commas = 0; m_gap = 0; m_mis = 0; m_loss = 0;
      m_data = 8'h00; e_valid = 0; e_strb = 0;
   endfunction

   function automatic void model_lose();
      m_mode = 0; m_commas = 0; m_gap = 0; m_mis = 0;
      if (m_loss < 255) m_loss++;
   endfunction

   function automatic void model_step(bit b);
      logic [7:0] w;
      bit on_boundary;
      bitq.push_back(b);
      if (bitq.size() > 8) void'(bitq.pop_front());
      w = 8'h00;
      foreach (bitq[i]) w = (w << 1) | 8'(bitq[i]);
      m_cyc++;
      e_valid = 0;
      e_strb  = 0;
      on_boundary = (m_mode != 0) && (((m_cyc - m_anchor) % 8) == 0);
      case (m_mode)
         0: if (w == COMMA) begin
               m_anchor = m_cyc;
               m_commas = 1;
               m_mode   = (LOCK_N == 1) ? 2 : 1;
            end
         1: if (on_boundary) begin
               if (w == COMMA) begin
                  m_commas++;
                  if (m_commas == LOCK_N) m_mode = 2;
               end else begin
                  m_commas = 0;
                  m_mode   = 0;
               end
            end
         default: begin
            if (on_boundary) begin
               e_strb = 1;
               if (w == COMMA) begin
                  m_gap = 0;
                  m_mis = 0;
               end else begin
                  m_data  = w;
                  e_valid = 1;
                  m_gap++;
                  if (m_gap == GAP_N) model_lose();
               end
            end else if (w == COMMA) begin
               m_mis++;
               if (m_mis == MIS_N) model_lose();
            end
         end
      endcase
   endfunction

   task automatic step(input logic b);
      logic [20:0] got, exp;
      data_in = b;
      if (reset) model_step(b);
      else       model_clear();
      @(posedge clk_32f);
      #1;
      tb_cyc++;
      got = {active, valid_out, byte_strb, data_out, sync_state, loss_count};
      exp = {(m_mode == 2), e_valid, e_strb, m_data, 2'(m_mode), 8'(m_loss)};
      if (got !== exp) begin
         trace_bad++;
         if (trace_bad == 1) begin
            first_got = got;
            first_exp = exp;
         end
      end
      if (valid_out === 1'b1) begin
         n_valid++;
         vq.push_back(data_out);
         vt.push_back(tb_cyc);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) step(b[i]);
   endtask

   task automatic lock_up();
      repeat (LOCK_N) send_byte(COMMA);
   endtask

   task automatic mis_pairs(input int n);
      repeat (n) begin
         send_byte(MIS_A);
         send_byte(MIS_B);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (4) step(1'($urandom));
      reset = 1'b1;
      trace_bad = 0;
      n_valid   = 0;
      vq.delete();
      vt.delete();
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      trace_bad = 0;
      repeat (20) step(1'($urandom));
      checks++;
      if ({active, valid_out, byte_strb, data_out, sync_state, loss_count} !== 21'd0) begin
         errors++;
         $display("FAIL reset_hold: outputs %h expected 0", {active, valid_out, byte_strb, data_out, sync_state, loss_count});
      end
      reset = 1'b1;
      lock_up();
      send_byte(8'h5A);
      checks++;
      if (active !== 1'b1 || data_out !== 8'h5A) begin
         errors++;
         $display("FAIL reset_prelock: active %b data %h expected 1 5a", active, data_out);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({active, valid_out, byte_strb, data_out, sync_state, loss_count} !== 21'd0) begin
         errors++;
         $display("FAIL reset_async: outputs %h expected 0", {active, valid_out, byte_strb, data_out, sync_state, loss_count});
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL reset_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   task automatic test_lock_offset();
      do_reset();
      repeat (3) step(1'($urandom));
      repeat (LOCK_N - 1) send_byte(COMMA);
      for (int i = 7; i >= 1; i--) step(COMMA[i]);
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL lock_early: active %b expected 0", active);
      end
      step(COMMA[0]);
      checks++;
      if (active !== 1'b1 || sync_state !== 2'b10) begin
         errors++;
         $display("FAIL lock_edge: active %b state %b expected 1 10", active, sync_state);
      end
      send_byte(8'h55);
      send_byte(8'hA3);
      checks++;
      if (n_valid !== 2 || vq.size() != 2) begin
         errors++;
         $display("FAIL lock_count: %0d pulses expected 2", n_valid);
      end else begin
         checks++;
         if (vq[0] !== 8'h55 || vq[1] !== 8'hA3) begin
            errors++;
            $display("FAIL lock_data: got %h %h expected 55 a3", vq[0], vq[1]);
         end
         checks++;
         if (vt[1] - vt[0] != 8) begin
            errors++;
            $display("FAIL lock_spacing: got %0d expected 8", vt[1] - vt[0]);
         end
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL lock_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   task automatic test_short_preamble();
      do_reset();
      repeat ($urandom_range(0, 7)) step(1'($urandom));
      send_byte(COMMA);
      send_byte(COMMA);
      checks++;
      if (sync_state !== 2'b01) begin
         errors++;
         $display("FAIL short_count: state %b expected 01", sync_state);
      end
      send_byte(COMMA);
      send_byte(8'h55);
      checks++;
      if (sync_state !== 2'b00 || active !== 1'b0) begin
         errors++;
         $display("FAIL short_state: state %b active %b expected 00 0", sync_state, active);
      end
      send_byte(8'h00);
      send_byte(8'h00);
      checks++;
      if (n_valid !== 0) begin
         errors++;
         $display("FAIL short_valid: %0d pulses expected 0", n_valid);
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL short_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   task automatic test_gap_loss();
      do_reset();
      lock_up();
      repeat (GAP_N - 1) send_byte(8'h00);
      checks++;
      if (sync_state !== 2'b10) begin
         errors++;
         $display("FAIL gap_hold15: state %b expected 10", sync_state);
      end
      send_byte(8'h00);
      checks++;
      if (n_valid !== GAP_N || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL gap_pulses: %0d pulses last %b expected %0d 1", n_valid, valid_out, GAP_N);
      end
      checks++;
      if (sync_state !== 2'b00 || active !== 1'b0 || loss_count !== 8'd1) begin
         errors++;
         $display("FAIL gap_loss: state %b active %b loss %0d expected 00 0 1", sync_state, active, loss_count);
      end
      do_reset();
      lock_up();
      repeat (GAP_N - 1) send_byte(8'h00);
      send_byte(COMMA);
      repeat (4) send_byte(8'h00);
      checks++;
      if (sync_state !== 2'b10 || loss_count !== 8'd0 || n_valid !== GAP_N + 3) begin
         errors++;
         $display("FAIL gap_refresh: state %b loss %0d pulses %0d expected 10 0 %0d", sync_state, loss_count, n_valid, GAP_N + 3);
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL gap_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      lock_up();
      mis_pairs(MIS_N - 1);
      checks++;
      if (sync_state !== 2'b10) begin
         errors++;
         $display("FAIL mis_hold3: state %b expected 10", sync_state);
      end
      mis_pairs(1);
      checks++;
      if (sync_state !== 2'b00 || active !== 1'b0 || loss_count !== 8'd1) begin
         errors++;
         $display("FAIL mis_loss: state %b active %b loss %0d expected 00 0 1", sync_state, active, loss_count);
      end
      do_reset();
      lock_up();
      mis_pairs(MIS_N - 1);
      send_byte(COMMA);
      mis_pairs(MIS_N - 1);
      checks++;
      if (sync_state !== 2'b10 || active !== 1'b1 || loss_count !== 8'd0) begin
         errors++;
         $display("FAIL mis_clear: state %b active %b loss %0d expected 10 1 0", sync_state, active, loss_count);
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL mis_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         do_reset();
         repeat ($urandom_range(0, 7)) step(1'($urandom));
         lock_up();
         for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
               0, 1:    send_byte(COMMA);
               2:       step(1'($urandom));
               3:       mis_pairs(1);
               default: send_byte(8'($urandom));
            endcase
         end
         checks++;
         if (trace_bad !== 0) begin
            errors++;
            $display("FAIL random_trace round %0d: %0d bad cycles first got %h expected %h", r, trace_bad, first_got, first_exp);
         end
      end
   endtask

   task automatic test_saturation();
      int exp_loss;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         lock_up();
         mis_pairs(MIS_N);
         exp_loss = (i + 1 > 255) ? 255 : i + 1;
         checks++;
         if (loss_count !== 8'(exp_loss)) begin
            errors++;
            $display("FAIL sat_loss iter %0d: got %0d expected %0d", i, loss_count, exp_loss);
         end
      end
      checks++;
      if (trace_bad !== 0) begin
         errors++;
         $display("FAIL sat_trace: %0d bad cycles first got %h expected %h", trace_bad, first_got, first_exp);
      end
   endtask

   initial begin
      trace_bad = 0;
      tb_cyc    = 0;
      n_valid   = 0;
      first_got = '0;
      first_exp = '0;
      model_clear();
      test_reset();
      test_lock_offset();
      test_short_preamble();
      test_gap_loss();
      test_misaligned();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
